// File: rtl/dvp_pkg.sv
`default_nettype none
// ============================================================================
// dvp_pkg : DVP state encoding, bus widths and RGB565 byte ordering
// Rev 1.0 : initial release
// ============================================================================
package dvp_pkg;

  localparam int DVP_DATA_W = 8;
  localparam int DVP_PIX_W  = 16;

  // RGB565 pixels leave the sensor high byte first
  localparam bit RGB565_HIGH_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBLANK = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4
  } dvp_state_e;

  function automatic logic [DVP_DATA_W-1:0] rgb565_byte(
    input logic [DVP_PIX_W-1:0] pix,
    input logic                 second
  );
    logic take_high;
    take_high = RGB565_HIGH_FIRST ? ~second : second;
    return take_high ? pix[15:8] : pix[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_pclk_gen.sv
`default_nettype none
// ============================================================================
// dvp_pclk_gen : divided PCLK with a tick strobe on each falling edge
// Rev 1.0 : initial release
// ============================================================================
module dvp_pclk_gen #(
  parameter int PCLK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic pclk_o,
  output logic tick_o
);

  localparam int CNT_W = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PCLK_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pclk_q, pclk_d;
  logic             wrap;

  always_comb begin
    wrap   = (cnt_q == CNT_LAST);
    cnt_d  = cnt_q;
    pclk_d = pclk_q;
    if (!run_i) begin
      cnt_d  = '0;
      pclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      pclk_d = ~pclk_q;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pclk_q <= pclk_d;
    end
  end

  // Tick marks the cycle whose closing edge drops PCLK
  assign tick_o = run_i & wrap & pclk_q;
  assign pclk_o = pclk_q;

endmodule
`default_nettype wire

// File: rtl/dvp_camera_transmitter.sv
`default_nettype none
// ============================================================================
// dvp_camera_transmitter : RGB565 stream to DVP (PCLK/VSYNC/HREF/D) source
// Rev 1.0 : initial release
// ============================================================================
module dvp_camera_transmitter
  import dvp_pkg::*;
#(
  parameter int FRAME_W      = 640,
  parameter int FRAME_H      = 480,
  parameter int VSYNC_LINES  = 3,
  parameter int VBLANK_LINES = 17,
  parameter int HBLANK_BYTES = 144,
  parameter int PCLK_HALF    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en_i,
  input  logic [DVP_PIX_W-1:0]  pix_data_i,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  output logic                  dvp_pclk_o,
  output logic                  dvp_vsync_o,
  output logic                  dvp_href_o,
  output logic [DVP_DATA_W-1:0] dvp_d_o,
  output logic                  frame_busy_o,
  output logic                  underrun_o
);

  localparam int LINE_BYTES = 2 * FRAME_W;
  localparam int LINE_TICKS = LINE_BYTES + HBLANK_BYTES;
  localparam int TICK_W     = (LINE_TICKS > 1) ? $clog2(LINE_TICKS) : 1;
  localparam int MAX_A      = (FRAME_H > VSYNC_LINES) ? FRAME_H : VSYNC_LINES;
  localparam int MAX_LINES  = (MAX_A > VBLANK_LINES) ? MAX_A : VBLANK_LINES;
  localparam int LINE_W     = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  localparam logic [TICK_W-1:0] LINE_LAST = TICK_W'(LINE_TICKS - 1);
  localparam logic [TICK_W-1:0] ACT_LAST  = TICK_W'(LINE_BYTES - 1);
  localparam logic [TICK_W-1:0] HB_LAST   = TICK_W'(HBLANK_BYTES - 1);
  localparam logic [LINE_W-1:0] VS_LAST   = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] VB_LAST   = LINE_W'(VBLANK_LINES - 1);
  localparam logic [LINE_W-1:0] FH_LAST   = LINE_W'(FRAME_H - 1);

  dvp_state_e state_q, state_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [DVP_PIX_W-1:0]  hold_q, hold_d;
  logic                  full_q, full_d;
  logic                  miss_q, miss_d;
  logic                  vsync_q, vsync_d;
  logic                  href_q, href_d;
  logic [DVP_DATA_W-1:0] d_q, d_d;
  logic                  busy_q, busy_d;
  logic                  underrun_q, underrun_d;

  logic tick;
  logic run;
  logic consume;
  logic start_pixel;
  logic load;

  assign run = (state_q != ST_IDLE) | tx_en_i;

  dvp_pclk_gen #(
    .PCLK_HALF (PCLK_HALF)
  ) u_pclk_gen (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run),
    .pclk_o (dvp_pclk_o),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    line_d      = line_q;
    vsync_d     = vsync_q;
    href_d      = href_q;
    d_d         = d_q;
    busy_d      = busy_q;
    miss_d      = miss_q;
    underrun_d  = underrun_q;
    consume     = 1'b0;
    start_pixel = 1'b0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (tx_en_i) begin
            state_d    = ST_VSYNC;
            tick_cnt_d = '0;
            line_d     = '0;
            vsync_d    = 1'b1;
            busy_d     = 1'b1;
          end
        end
        ST_VSYNC: begin
          if (tick_cnt_q == LINE_LAST) begin
            tick_cnt_d = '0;
            if (line_q == VS_LAST) begin
              line_d  = '0;
              state_d = ST_VBLANK;
              vsync_d = 1'b0;
            end else begin
              line_d = line_q + LINE_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        ST_VBLANK: begin
          if (tick_cnt_q == LINE_LAST) begin
            tick_cnt_d = '0;
            if (line_q == VB_LAST) begin
              line_d      = '0;
              state_d     = ST_ACTIVE;
              start_pixel = 1'b1;
            end else begin
              line_d = line_q + LINE_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (tick_cnt_q == ACT_LAST) begin
            state_d    = ST_HBLANK;
            tick_cnt_d = '0;
            href_d     = 1'b0;
            d_d        = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
            // Even byte on the wire now, so the next one is the pixel's second byte
            if (!tick_cnt_q[0]) begin
              d_d     = miss_q ? '0 : rgb565_byte(hold_q, 1'b1);
              consume = ~miss_q;
            end else begin
              start_pixel = 1'b1;
            end
          end
        end
        ST_HBLANK: begin
          if (tick_cnt_q == HB_LAST) begin
            tick_cnt_d = '0;
            if (line_q != FH_LAST) begin
              line_d      = line_q + LINE_W'(1);
              state_d     = ST_ACTIVE;
              start_pixel = 1'b1;
            end else if (tx_en_i) begin
              line_d  = '0;
              state_d = ST_VSYNC;
              vsync_d = 1'b1;
            end else begin
              line_d  = '0;
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // An empty holder at a pixel's first byte blanks both of its bytes
    if (start_pixel) begin
      href_d = 1'b1;
      if (full_q) begin
        d_d    = rgb565_byte(hold_q, 1'b0);
        miss_d = 1'b0;
      end else begin
        d_d        = '0;
        miss_d     = 1'b1;
        underrun_d = 1'b1;
      end
    end
  end

  // Ready reopens in the cycle the holder drains so the next pixel lands at once
  assign pix_ready_o = ~rst & (~full_q | consume);
  assign load        = pix_valid_i & pix_ready_o;

  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (load) begin
      hold_d = pix_data_i;
      full_d = 1'b1;
    end else if (consume) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      line_q     <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      miss_q     <= 1'b0;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      d_q        <= '0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      line_q     <= line_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      miss_q     <= miss_d;
      vsync_q    <= vsync_d;
      href_q     <= href_d;
      d_q        <= d_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign dvp_vsync_o  = vsync_q;
  assign dvp_href_o   = href_q;
  assign dvp_d_o      = d_q;
  assign frame_busy_o = busy_q;
  assign underrun_o   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dvp_camera_transmitter.sv
`default_nettype none
// ============================================================================
// tb_dvp_camera_transmitter : scoreboard bench for the DVP transmitter
// Rev 1.0 : initial release
// ============================================================================
module tb_dvp_camera_transmitter;

  localparam int FW = 4;
  localparam int FH = 2;
  localparam int VSL = 1;
  localparam int VBL = 1;
  localparam int HB = 4;
  localparam int PH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b1;
  logic [15:0] pix_data = 16'h1234;
  logic        pix_valid = 1'b1;
  logic        pix_ready;
  logic        dvp_pclk;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_d;
  logic        frame_busy;
  logic        underrun;

  dvp_camera_transmitter #(
    .FRAME_W      (FW),
    .FRAME_H      (FH),
    .VSYNC_LINES  (VSL),
    .VBLANK_LINES (VBL),
    .HBLANK_BYTES (HB),
    .PCLK_HALF    (PH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_en_i      (tx_en),
    .pix_data_i   (pix_data),
    .pix_valid_i  (pix_valid),
    .pix_ready_o  (pix_ready),
    .dvp_pclk_o   (dvp_pclk),
    .dvp_vsync_o  (dvp_vsync),
    .dvp_href_o   (dvp_href),
    .dvp_d_o      (dvp_d),
    .frame_busy_o (frame_busy),
    .underrun_o   (underrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int href_rises = 0;
  int href_falls = 0;
  int mon_pulses = 0;
  bit busy_low_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  always @(negedge clk) if (!frame_busy) busy_low_seen = 1'b1;

  // Monitor: samples the DVP bus just after each PCLK rise
  initial begin
    bit prev_vs, prev_href, have_frame, in_vblank, seen_line;
    int vs_len, blank_len, href_len, hb_len, ticks_since;
    logic [7:0] e;
    prev_vs = 0; prev_href = 0; have_frame = 0; in_vblank = 0; seen_line = 0;
    vs_len = 0; blank_len = 0; href_len = 0; hb_len = 0; ticks_since = 0;
    forever begin
      @(posedge dvp_pclk);
      #1;
      if (dvp_vsync && !prev_vs) begin
        if (have_frame) check("frame_href_pulses", mon_pulses, 2);
        if (have_frame && !busy_low_seen) check("vsync_period", ticks_since, 48);
        have_frame = 1; mon_pulses = 0; vs_len = 0; seen_line = 0; in_vblank = 0;
        busy_low_seen = 1'b0;
        ticks_since = 1;
      end else begin
        ticks_since++;
      end
      if (dvp_vsync) begin
        vs_len++;
        check("vsync_implies_busy", frame_busy, 1);
      end
      if (!dvp_vsync && prev_vs) begin
        check("vsync_len", vs_len, 12);
        in_vblank = 1; blank_len = 0;
      end
      if (in_vblank && !dvp_href) blank_len++;
      if (dvp_href && !prev_href) begin
        href_rises++; mon_pulses++; href_len = 0;
        if (in_vblank) begin
          check("vblank_len", blank_len, 12);
          in_vblank = 0;
        end else if (seen_line) begin
          check("hblank_len", hb_len, 4);
        end
      end
      if (dvp_href) begin
        href_len++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_byte: got 0x%0h with empty scoreboard", dvp_d);
        end else begin
          e = exp_q.pop_front();
          check("href_byte", dvp_d, e);
        end
      end else begin
        check("d_zero_href_low", dvp_d, 0);
      end
      if (!dvp_href && prev_href) begin
        href_falls++;
        check("href_len", href_len, 8);
        hb_len = 1; seen_line = 1;
      end else if (!dvp_href && seen_line) begin
        hb_len++;
      end
      prev_vs = dvp_vsync;
      prev_href = dvp_href;
    end
  end

  task automatic send_pixel(input logic [15:0] p);
    int c;
    c = 0;
    pix_data = p;
    pix_valid = 1'b1;
    while (!pix_ready && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (!pix_ready) begin
      timeout_fail("pixel_handshake");
    end else begin
      @(posedge clk);
      exp_q.push_back(p[15:8]);
      exp_q.push_back(p[7:0]);
      #1;
    end
  endtask

  task automatic wait_rises(input int n);
    int c;
    c = 0;
    while (href_rises < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (href_rises < n) timeout_fail("wait_href_rise");
  endtask

  task automatic wait_falls(input int n);
    int c;
    c = 0;
    while (href_falls < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (href_falls < n) timeout_fail("wait_href_fall");
  endtask

  task automatic wait_busy_low();
    int c;
    c = 0;
    while (frame_busy && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (frame_busy) timeout_fail("wait_frame_end");
  endtask

  logic [15:0] frame01 [16] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978,
                                16'h8001, 16'h7FFE, 16'hCAFE, 16'hBEEF,
                                16'h0102, 16'h0304, 16'hF00F, 16'h55AA};
  logic [15:0] frame3 [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                              16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0708};

  initial begin
    int bad;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs",
            {dvp_pclk, dvp_vsync, dvp_href, dvp_d, frame_busy, underrun, pix_ready}, 0);
    end
    rst = 1'b0;
    #1;

    fork
      begin
        for (int i = 0; i < 16; i++) send_pixel(frame01[i]);
        pix_valid = 1'b0;
      end
      begin
        int c1, c2;
        logic prev;
        c1 = -1; c2 = -1; prev = 1'b0;
        for (int i = 0; i < 40 && c2 < 0; i++) begin
          @(negedge clk);
          if (dvp_pclk && !prev) begin
            if (c1 < 0) c1 = i;
            else c2 = i;
          end
          prev = dvp_pclk;
        end
        check("pclk_period", c2 - c1, 4);
      end
      begin
        wait_rises(3);
        tx_en = 1'b0;
      end
    join

    wait_busy_low();
    @(negedge clk);
    check("underrun_clean", underrun, 0);
    check("ready_when_empty", pix_ready, 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (dvp_pclk || dvp_vsync || dvp_href || frame_busy) bad++;
    end
    check("idle_quiet", bad, 0);

    send_pixel(16'hA55A);
    pix_valid = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (pix_ready) bad++;
    end
    check("prefetch_holds_ready_low", bad, 0);

    tx_en = 1'b1;
    send_pixel(16'hC3C3);
    send_pixel(16'h0001);
    send_pixel(16'hFF00);
    pix_valid = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
    wait_falls(6);
    check("underrun_set", underrun, 1);

    fork
      begin
        for (int i = 0; i < 8; i++) send_pixel(frame3[i]);
        pix_valid = 1'b0;
      end
      begin
        wait_rises(7);
        tx_en = 1'b0;
      end
    join
    wait_busy_low();
    @(negedge clk);
    check("underrun_sticky", underrun, 1);
    check("scoreboard_drained", exp_q.size(), 0);
    check("last_frame_pulses", mon_pulses, 2);
    check("total_lines", href_falls, 8);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_clears",
          {dvp_pclk, dvp_vsync, dvp_href, dvp_d, frame_busy, underrun, pix_ready}, 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
